gesture_dir_ctrl: RTL
=====================

# gesture_dir_ctrl

Converts the PAJ7620 gesture flag byte (`po_data` from `i2c_ctrl`) into validated snake direction commands for `my_snake`. It detects new gestures and rejects multi-flag bytes and 180° reversals. A post-acceptance hold-off filters repeated gestures. Accepted directions are buffered in a small FIFO and applied one per snake `move` tick, so quick gesture pairs (e.g. up-then-left) survive a single game step.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000: sys_clk frequency in Hz.
- `HOLD_MS`, 200: hold-off after an accepted gesture, in ms. 0 disables hold-off.
- `FIFO_DEPTH`, 2: direction queue depth. Power of two, 2..8.

Ports:
- `sys_clk`, in, 1: system clock.
- `sys_rst_n`, in, 1: reset. One clock; reset is asynchronous and active-low.
- `po_data`, in, 8: gesture flags. bit0 up, bit1 down, bit2 left, bit3 right, bit4 forward, bit5 backward, bit6 cw, bit7 ccw.
- `move`, in, 1: one-cycle pulse from `my_snake` at each game step.
- `dir`, out, 2: current direction. 0 up, 1 down, 2 left, 3 right.
- `dir_upd`, out, 1: one-cycle pulse when `dir` changes value.
- `q_cnt`, out, $clog2(FIFO_DEPTH)+1: number of queued commands.
- `drop`, out, 1: one-cycle pulse when a valid gesture is lost because the queue is full.
- `pause`, out, 1: pause level (see Configuration).
- `busy`, out, 1: high while in HOLD.

## Operation
- `po_r` register: samples `po_data` every cycle, including during HOLD.
- Event condition: `po_data != po_r` and `po_data != 0`.
- Event classification, evaluated in IDLE only:
  - Exactly one of bits 3:0 set, bits 7:4 zero: direction candidate.
  - Only bit4 or only bit5 set: pause toggle (with macro only).
  - Anything else: ignored. No state change, no hold-off.
- Reversal reference: the FIFO tail entry if `q_cnt > 0`, else `dir`.
- Reversal rule: a candidate equal to the opposite of the reference is rejected silently and starts no hold-off. Opposite pairs are up/down and left/right.
- A candidate equal to the reference is accepted and pushed; a duplicate is harmless.
- Accepted candidate with queue not full: push, then IDLE→HOLD.
- Accepted candidate with queue full: `drop` pulses, nothing is pushed, IDLE→HOLD.
- HOLD: counter runs 0..HOLD_CYC−1, where HOLD_CYC = CLK_FREQ/1000*HOLD_MS. At terminal count → IDLE. Events seen during HOLD are discarded, not deferred.
- `move` with `q_cnt > 0`: pop the head into `dir`. `dir_upd` pulses only if the popped value differs from the old `dir`.
- `move` with an empty queue: no effect.
- Simultaneous push and pop in one cycle:
  - Both take effect and `q_cnt` is unchanged.
  - When full, the pop frees a slot, so the push succeeds and `drop` stays low.
  - Reversal reference is the pre-pop tail; with an empty queue it is the pre-update `dir`.

## Timing
- Reset values: `dir`=3 (right), `dir_upd`=0, `q_cnt`=0, `drop`=0, `pause`=0, `busy`=0, state IDLE, `po_r`=0, FIFO pointers 0.
- Gesture at cycle N (event true):
  - Push visible in `q_cnt` at N+1.
  - `busy`=1 from N+1 through N+HOLD_CYC; IDLE again at N+HOLD_CYC+1.
- `move` at cycle M: `dir` and `dir_upd` update at M+1.
- `drop`: registered, high for exactly one cycle at N+1.
- Reset mid-HOLD or with a non-empty queue: everything returns to reset values immediately (asynchronous). A gesture byte still present after release counts as an event, because `po_r` is 0.

## Configuration
- Macro: `GESTURE_PAUSE_EN`.
- Defined:
  - A bit4 or bit5 event toggles `pause` at N+1 and enters HOLD.
  - While `pause`=1, `move` pops nothing.
- Undefined:
  - `pause` is tied 0.
  - bit4 and bit5 bytes are ignored like any other invalid byte.

## Structure
- Shared package `snake_pkg`:
  - Direction codes `DIR_UP/DOWN/LEFT/RIGHT`.
  - Gesture bit indices `GES_UP..GES_CCW`.
  - `dir_opposite` function.
- Sub-module `dir_fifo`:
  - Synchronous FIFO, parameter `FIFO_DEPTH`, 2-bit data.
  - Ports: push/pop/full/empty/count/tail.
  - Supports same-cycle push+pop when full.
- Top level holds the classifier, the IDLE/HOLD FSM and the hold counter.

## Test plan
(Bench uses `CLK_FREQ`=1000, `HOLD_MS`=5, i.e. HOLD_CYC=5.)
1. Reset, then `po_data`=0x01 held → `q_cnt`=1 next cycle, `busy` high 5 cycles. A `move` pulse then gives `dir`=0 and `dir_upd` pulse.
2. `dir`=3, `po_data`=0x04 (left) → no push, `busy` stays 0. Then `po_data`=0x02 → accepted.
3. Three valid gestures spaced 10 cycles apart with no `move`, `FIFO_DEPTH`=2 → `q_cnt`=2 and `drop` pulses once on the third.
4. Queue full, gesture arrives in the same cycle as `move` → `q_cnt` stays 2, `drop`=0, head popped into `dir`.
5. `po_data`=0x05 (two flags), then 0x40 (cw) → no push, no hold. With `GESTURE_PAUSE_EN`, `po_data`=0x10 sets `pause`=1 and `move` is then ignored.
6. Assert `sys_rst_n` low mid-HOLD with `q_cnt`=1 → all outputs return to reset values asynchronously, `dir`=3.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared snake/gesture definitions: direction codes, gesture flag bit indices,
// controller state encoding and direction helpers.
package snake_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   localparam int unsigned GES_UP    = 0;
   localparam int unsigned GES_DOWN  = 1;
   localparam int unsigned GES_LEFT  = 2;
   localparam int unsigned GES_RIGHT = 3;
   localparam int unsigned GES_FWD   = 4;
   localparam int unsigned GES_BWD   = 5;
   localparam int unsigned GES_CW    = 6;
   localparam int unsigned GES_CCW   = 7;

   typedef enum logic {
      ST_IDLE,
      ST_HOLD
   } ctrl_state_t;

   // Codes are paired so that flipping bit0 yields the opposite direction.
   function automatic dir_t dir_opposite(input dir_t d);
      return dir_t'(d ^ 2'b01);
   endfunction

   function automatic dir_t ges_to_dir(input logic [3:0] flags);
      dir_t d;
      d = DIR_UP;
      if (flags[GES_DOWN])  d = DIR_DOWN;
      if (flags[GES_LEFT])  d = DIR_LEFT;
      if (flags[GES_RIGHT]) d = DIR_RIGHT;
      return d;
   endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small synchronous direction queue; a pop frees a slot for a push in the
// same cycle even when full.
module dir_fifo #(
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        push,
   input  logic                        pop,
   input  logic [1:0]                  wdata,
   output logic [1:0]                  head,
   output logic [1:0]                  tail,
   output logic                        full,
   output logic                        empty,
   output logic [$clog2(FIFO_DEPTH):0] count
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   logic [1:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] tail_ptr;
   logic          do_push;
   logic          do_pop;

   always_comb begin
      empty    = (count == '0);
      full     = (count == FULL_CNT);
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      tail_ptr = wr_ptr - 1'b1;
      head     = mem[rd_ptr];
      tail     = mem[tail_ptr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/gesture_dir_ctrl.sv
// PAJ7620 gesture byte to snake direction commands: classify, reject reversals,
// hold off repeats, queue accepted directions. Optional pause via GESTURE_PAUSE_EN.
module gesture_dir_ctrl
   import snake_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 50_000_000,
   parameter int unsigned HOLD_MS    = 200,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                        sys_clk,
   input  logic                        sys_rst_n,
   input  logic [7:0]                  po_data,
   input  logic                        move,
   output logic [1:0]                  dir,
   output logic                        dir_upd,
   output logic [$clog2(FIFO_DEPTH):0] q_cnt,
   output logic                        drop,
   output logic                        pause,
   output logic                        busy
);

   localparam int unsigned HOLD_CYC  = CLK_FREQ / 1000 * HOLD_MS;
   localparam int unsigned HCW       = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam int unsigned HOLD_LAST = (HOLD_CYC > 0) ? HOLD_CYC - 1 : 0;
   localparam logic [HCW-1:0] HOLD_LAST_W = HCW'(HOLD_LAST);

   ctrl_state_t    state, state_nx;
   logic [HCW-1:0] hold_cnt;
   logic [7:0]     po_r;
   dir_t           dir_q;
   logic           dir_upd_q;
   logic           drop_q;
   logic           pause_i;

   logic [1:0]     fifo_head, fifo_tail;
   logic           fifo_full, fifo_empty;

   logic           gesture_evt, in_idle, is_dir, dir_ok;
   logic           pop_en, push_en, drop_nx, pause_tgl, start_hold;
   dir_t           cand, ref_dir;

   always_comb begin
      in_idle     = (state == ST_IDLE);
      gesture_evt = (po_data != po_r) && (po_data != '0);
      is_dir      = (po_data[7:4] == '0) && $onehot(po_data[3:0]);
      cand        = ges_to_dir(po_data[3:0]);
      // The reference is the pre-pop tail, so a same-cycle pop never changes it.
      ref_dir     = fifo_empty ? dir_q : dir_t'(fifo_tail);
      dir_ok      = in_idle && gesture_evt && is_dir && (cand != dir_opposite(ref_dir));
      pop_en      = move && !fifo_empty && !pause_i;
      push_en     = dir_ok && (!fifo_full || pop_en);
      drop_nx     = dir_ok && fifo_full && !pop_en;
      start_hold  = dir_ok || pause_tgl;
   end

`ifdef GESTURE_PAUSE_EN
   logic pause_q;

   always_comb pause_tgl = in_idle && gesture_evt &&
                           ((po_data == (8'd1 << GES_FWD)) || (po_data == (8'd1 << GES_BWD)));

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) pause_q <= 1'b0;
      else if (pause_tgl) pause_q <= !pause_q;
   end

   assign pause_i = pause_q;
`else
   assign pause_tgl = 1'b0;
   assign pause_i   = 1'b0;
`endif

   dir_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_dir_fifo (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .push  (push_en),
      .pop   (pop_en),
      .wdata (cand),
      .head  (fifo_head),
      .tail  (fifo_tail),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (q_cnt)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state    <= ST_IDLE;
         hold_cnt <= '0;
      end else begin
         state    <= state_nx;
         hold_cnt <= (state == ST_HOLD) ? hold_cnt + 1'b1 : '0;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (start_hold && (HOLD_CYC != 0)) state_nx = ST_HOLD;
         ST_HOLD: if (hold_cnt == HOLD_LAST_W) state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (state == ST_HOLD);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         po_r      <= '0;
         dir_q     <= DIR_RIGHT;
         dir_upd_q <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         po_r      <= po_data;
         dir_upd_q <= pop_en && (fifo_head != dir_q);
         drop_q    <= drop_nx;
         if (pop_en) dir_q <= dir_t'(fifo_head);
      end
   end

   assign dir     = dir_q;
   assign dir_upd = dir_upd_q;
   assign drop    = drop_q;
   assign pause   = pause_i;

endmodule
